// File: rtl/encoder_64b66b_pkg.sv
// Shared 64b/66b constants: sync headers, block/word widths, scrambler taps.
package encoder_64b66b_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int BLOCK_W = 66;
  localparam int WORD_W  = 64;
  localparam int BUF_W   = 128;
  localparam int LVL_W   = 8;

  // Self-synchronous scrambler x^58 + x^39 + 1
  localparam int SCR_W = 58;
  localparam int TAP_A = 38;
  localparam int TAP_B = 57;

  typedef logic [SCR_W-1:0] scr_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    scr_state_t        state;
  } scr_result_t;

  // Scramble one 64-bit payload, bit 0 first; state[0] is the newest scrambled bit.
  function automatic scr_result_t scramble64(input scr_state_t s, input logic [WORD_W-1:0] d);
    scr_result_t r;
    logic        b;
    r.state = s;
    r.data  = '0;
    for (int i = 0; i < WORD_W; i++) begin
      b         = d[i] ^ r.state[TAP_A] ^ r.state[TAP_B];
      r.data[i] = b;
      r.state   = {r.state[SCR_W-2:0], b};
    end
    return r;
  endfunction

endpackage

// File: rtl/encoder_64b66b_scrambler.sv
// Payload scrambler: combinational output from the current state, state
// advances by 64 bits only when adv_i is set. BYPASS passes data through
// and freezes the state.
module scrambler
  import encoder_64b66b_pkg::*;
#(
  parameter bit         BYPASS = 1'b0,
  parameter scr_state_t SEED   = {SCR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adv_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o
);

  scr_state_t state_q;
  scr_state_t state_d;

  generate
    if (BYPASS) begin : g_bypass
      assign data_o  = data_i;
      assign state_d = state_q;
    end else begin : g_scr
      scr_result_t res;
      // Scramble the presented payload against the stored history.
      always_comb res = scramble64(state_q, data_i);
      assign data_o  = res.data;
      assign state_d = adv_i ? res.state : state_q;
    end
  endgenerate

  // Scrambler history register, returns to the seed on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SEED;
    else          state_q <= state_d;
  end

endmodule

// File: rtl/encoder_64b66b.sv
// 64b/66b transmit encoder: scrambles the payload, prepends the sync header
// and packs 66-bit blocks into 64-bit serial-order words through a 128-bit
// gearbox. Bits above lvl in the buffer are always zero, so new blocks are
// merged with a plain OR.
module encoder_64b66b
  import encoder_64b66b_pkg::*;
#(
  parameter bit         SCR_BYPASS = 1'b0,
  parameter logic [57:0] SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_axis_ttype,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic               tvalid_q;
  logic               push, pop;
  logic [WORD_W-1:0]  scr_data;
  logic [BLOCK_W-1:0] block;
  logic [BUF_W-1:0]   base;
  logic [BUF_W-1:0]   ins;
  logic [LVL_W-1:0]   pos;

  scrambler #(
    .BYPASS (SCR_BYPASS),
    .SEED   (SCR_SEED)
  ) u_scrambler (
    .clk     (clk),
    .reset_n (reset_n),
    .adv_i   (push),
    .data_i  (s_axis_tdata),
    .data_o  (scr_data)
  );

  // Ready never depends on tvalid; forced low while reset is held.
  assign s_axis_tready = reset_n &
                         ((lvl_q < 8'd64) | (m_axis_tready & (lvl_q < 8'd128)));
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = tvalid_q & m_axis_tready;
  assign block         = {scr_data, s_axis_ttype};
  assign m_axis_tdata  = buf_q[WORD_W-1:0];
  assign m_axis_tvalid = tvalid_q;

  // Gearbox next state: optional pop shift, then append the new block above the valid bits.
  always_comb begin
    base  = pop ? {{WORD_W{1'b0}}, buf_q[BUF_W-1:WORD_W]} : buf_q;
    pos   = pop ? (lvl_q - 8'd64) : lvl_q;
    ins   = {{(BUF_W-BLOCK_W){1'b0}}, block} << pos;
    buf_d = push ? (base | ins) : base;
    lvl_d = lvl_q;
    case ({push, pop})
      2'b11:   lvl_d = lvl_q + 8'd2;
      2'b10:   lvl_d = lvl_q + 8'd66;
      2'b01:   lvl_d = lvl_q - 8'd64;
      default: lvl_d = lvl_q;
    endcase
  end

  // Buffer, fill level and registered output-valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q    <= '0;
      lvl_q    <= '0;
      tvalid_q <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      lvl_q    <= lvl_d;
      tvalid_q <= (lvl_d >= 8'd64);
    end
  end

endmodule

// File: tb/tb_encoder_64b66b.sv
// Directed bench for encoder_64b66b: a bypass instance and a scrambling
// instance share the stimulus; a bit-queue scoreboard checks both output
// streams (the scrambled one through a descrambler model).
module tb_encoder_64b66b;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  ttype;
  logic [63:0] tdata;
  logic        tvalid;
  logic        mready;
  logic        byp_tready, scr_tready;
  logic [63:0] byp_tdata, scr_tdata;
  logic        byp_tvalid, scr_tvalid;

  int n_err    = 0;
  int n_checks = 0;
  int n_push   = 0;
  int n_pop    = 0;

  bit          exp_q[$];
  logic [63:0] words[$];
  logic [57:0] ds_state;
  int          blk_pos;

  always #5 clk = ~clk;

  encoder_64b66b #(.SCR_BYPASS(1'b1), .SCR_SEED(SEED)) dut_byp (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axis_ttype  (ttype),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (byp_tready),
    .m_axis_tdata  (byp_tdata),
    .m_axis_tvalid (byp_tvalid),
    .m_axis_tready (mready)
  );

  encoder_64b66b #(.SCR_BYPASS(1'b0), .SCR_SEED(SEED)) dut_scr (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axis_ttype  (ttype),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (scr_tready),
    .m_axis_tdata  (scr_tdata),
    .m_axis_tvalid (scr_tvalid),
    .m_axis_tready (mready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ds_state = SEED;
    blk_pos  = 0;
  endtask

  // One clock: sample handshakes, score any output word, record any input block.
  task automatic tick();
    logic [63:0] ew, dw;
    logic        r;
    #1;
    if (byp_tvalid && mready) begin
      n_pop++;
      words.push_back(byp_tdata);
      chk("scr_tvalid", 64'(scr_tvalid), 64'd1);
      if (exp_q.size() < 64) begin
        chk("underflow", 64'(exp_q.size()), 64'd64);
      end else begin
        for (int i = 0; i < 64; i++) ew[i] = exp_q.pop_front();
        for (int i = 0; i < 64; i++) begin
          r = scr_tdata[i];
          if (blk_pos < 2) dw[i] = r;
          else begin
            dw[i]    = r ^ ds_state[38] ^ ds_state[57];
            ds_state = {ds_state[56:0], r};
          end
          blk_pos = (blk_pos == 65) ? 0 : blk_pos + 1;
        end
        chk("byp_word", byp_tdata, ew);
        chk("scr_word", dw, ew);
      end
    end
    if (tvalid && byp_tready) begin
      n_push++;
      for (int i = 0; i < 2; i++)  exp_q.push_back(ttype[i]);
      for (int i = 0; i < 64; i++) exp_q.push_back(tdata[i]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] hold, d, w;

    // ---- reset state ----
    reset_n = 1'b0; tvalid = 1'b0; mready = 1'b0; ttype = 2'b01; tdata = '0;
    model_reset();
    @(negedge clk);
    chk("rst_tvalid", 64'(byp_tvalid), 64'd0);
    chk("rst_tdata",  byp_tdata, 64'd0);
    chk("rst_tready", 64'(byp_tready), 64'd0);
    chk("rst_scr_tdata", scr_tdata, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("tready_after_rst", 64'(byp_tready), 64'd1);
    @(negedge clk);

    // ---- 32 zero data blocks, continuous, sink always ready ----
    words.delete(); n_push = 0; n_pop = 0;
    tvalid = 1'b1; mready = 1'b1; ttype = 2'b01; tdata = '0;
    for (int c = 0; c < 34; c++) begin
      if (c == 32) tvalid = 1'b0;
      tick();
      if (c == 32) chk("pops_after_33_cycles", 64'(n_pop), 64'd32);
    end
    chk("rate_pushes", 64'(n_push), 64'd32);
    chk("rate_pops", 64'(n_pop), 64'd33);
    for (int k = 0; k < 33; k++)
      chk("zero_stream_word", words[k], (k < 32) ? (64'h1 << (2 * k)) : 64'h0);
    chk("zero_stream_idle", 64'(byp_tvalid), 64'd0);

    // ---- fill to lvl 128, then stall the sink for 10 cycles ----
    tvalid = 1'b1; mready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      tdata = {$urandom, $urandom};
      tick();
    end
    chk("lvl_full", 64'(dut_byp.lvl_q), 64'd128);
    mready = 1'b0;
    hold   = byp_tdata;
    for (int c = 0; c < 10; c++) begin
      tdata = {$urandom, $urandom};
      tick();
      chk("stall_tready", 64'(byp_tready), 64'd0);
      chk("stall_tvalid", 64'(byp_tvalid), 64'd1);
      chk("stall_tdata",  byp_tdata, hold);
    end
    tvalid = 1'b0; mready = 1'b1;
    for (int c = 0; c < 10 && byp_tvalid; c++) tick();
    chk("stall_drain_empty", 64'(exp_q.size()), 64'd0);
    chk("stall_drain_tvalid", 64'(byp_tvalid), 64'd0);

    // ---- illegal header 2'b11 forwarded unchanged ----
    d = 64'hA5C3_0F1E_9B7D_2468;
    ttype = 2'b11; tdata = d; tvalid = 1'b1;
    tick();
    tvalid = 1'b0; ttype = 2'b01;
    words.delete();
    tick();
    chk("ill_words", 64'(words.size()), 64'd1);
    w = words[0];
    chk("ill_header", 64'(w[1:0]), 64'd3);
    chk("ill_payload", 64'(w[63:2]), 64'(d[61:0]));
    repeat (5) tick();
    chk("residual_hold_tvalid", 64'(byp_tvalid), 64'd0);
    chk("residual_hold_lvl", 64'(dut_byp.lvl_q), 64'd2);

    // ---- build lvl 34, then reset mid-cycle ----
    tvalid = 1'b1; mready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tdata = {$urandom, $urandom};
      tick();
    end
    tvalid = 1'b0;
    for (int c = 0; c < 10 && byp_tvalid; c++) tick();
    chk("lvl_34", 64'(dut_byp.lvl_q), 64'd34);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_tvalid", 64'(byp_tvalid), 64'd0);
    chk("async_rst_scr_tvalid", 64'(scr_tvalid), 64'd0);
    chk("async_rst_tready", 64'(byp_tready), 64'd0);
    chk("async_rst_tdata", byp_tdata, 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    d = 64'h0123_4567_89AB_CDEF;
    ttype = 2'b01; tdata = d; tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    words.delete();
    tick();
    chk("post_rst_words", 64'(words.size()), 64'd1);
    chk("post_rst_word0", words[0], {d[61:0], 2'b01});
    chk("post_rst_lvl", 64'(dut_byp.lvl_q), 64'd2);

    // ---- random traffic, 50% valid/ready, 1000 blocks ----
    n_push = 0; n_pop = 0;
    for (int c = 0; c < 6000 && n_push < 1000; c++) begin
      tvalid = 1'($urandom_range(0, 1));
      mready = 1'($urandom_range(0, 1));
      tdata  = {$urandom, $urandom};
      ttype  = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
      tick();
    end
    chk("rand_blocks", 64'(n_push >= 1000), 64'd1);
    tvalid = 1'b0; mready = 1'b1;
    repeat (6) tick();
    chk("rand_final_tvalid", 64'(byp_tvalid), 64'd0);
    chk("rand_final_lvl", 64'(dut_byp.lvl_q), 64'(exp_q.size()));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
